// File: rtl/overcurrent_guard_n_if.sv
// Bus bundle for overcurrent_guard_n: packed samples/thresholds in, relay and status out.
// master = sensor/control side, slave = the guard itself.
interface overcurrent_guard_n_if #(
  parameter int N_CH = 3,
  parameter int DW   = 16
);
  logic [N_CH*DW-1:0] samples;
  logic [N_CH*DW-1:0] thresholds;
  logic [N_CH-1:0]    clear_trip;
  logic [N_CH-1:0]    relay;
  logic               buzzer;
  logic [N_CH-1:0]    tripped;
  logic [N_CH-1:0]    trip_event;
  logic               startup_done;

  modport master (
    output samples, thresholds, clear_trip,
    input  relay, buzzer, tripped, trip_event, startup_done
  );

  modport slave (
    input  samples, thresholds, clear_trip,
    output relay, buzzer, tripped, trip_event, startup_done
  );
endinterface

// File: rtl/overcurrent_guard_n.sv
// N-channel overcurrent guard: startup hold, per-channel threshold, debounce, latching relay trip.
// Define AUTO_RETRY_EN for timed auto-reclose with a per-channel retry limit and a LOCKOUT state.
module overcurrent_guard_n #(
  parameter int N_CH        = 3,
  parameter int DW          = 16,
  parameter int STARTUP_CYC = 150000000,
  parameter int DEBOUNCE    = 1000,
  parameter int NEG_LIM     = 32000,
  parameter int RETRY_CYC   = 50000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  overcurrent_guard_n_if.slave bus
);

  localparam int SU_W  = $clog2(STARTUP_CYC + 1);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DW:0] NEG_LIM_W = (DW+1)'(NEG_LIM);
`ifdef AUTO_RETRY_EN
  localparam int RT_W  = $clog2(RETRY_CYC + 1);
  localparam int RC_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`endif

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TRIPPED = 2'd2
`ifdef AUTO_RETRY_EN
    ,
    ST_LOCKOUT = 2'd3
`endif
  } state_t;

  logic [SU_W-1:0] r_su_cnt;
  logic            r_startup_done;
  logic            w_startup_fire;
  logic [N_CH-1:0] w_relay_next;
  logic [N_CH-1:0] w_tripped_next;
  logic [N_CH-1:0] w_event_next;
  logic [N_CH-1:0] r_relay;
  logic [N_CH-1:0] r_tripped;
  logic [N_CH-1:0] r_event;
  logic            r_buzzer;

  // Retry timing is inert unless AUTO_RETRY_EN is defined; the range check keeps it referenced.
  if (STARTUP_CYC < 1 || DEBOUNCE < 1 || RETRY_CYC < 1 || MAX_RETRY < 0) begin : g_param_range_violation
  end

  assign w_startup_fire = !r_startup_done && (r_su_cnt == SU_W'(STARTUP_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_su_cnt       <= '0;
      r_startup_done <= 1'b0;
    end else if (w_startup_fire) begin
      r_startup_done <= 1'b1;
    end else if (!r_startup_done) begin
      r_su_cnt <= r_su_cnt + SU_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DW-1:0]    w_sample;
      logic [DW-1:0]    w_thr;
      logic             w_over;
      logic             w_clear_ok;
      logic             w_trip;
      state_t           r_state;
      state_t           w_state_next;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
`ifdef AUTO_RETRY_EN
      logic [RT_W-1:0]  r_rt;
      logic [RT_W-1:0]  w_rt_next;
      logic [RC_W-1:0]  r_retries;
      logic [RC_W-1:0]  w_retries_next;
`endif

      assign w_sample   = bus.samples[gi*DW +: DW];
      assign w_thr      = bus.thresholds[gi*DW +: DW];
      // Codes at or above NEG_LIM are a negative reading from the sensor, never an overload.
      assign w_over     = (w_sample > w_thr) && ({1'b0, w_sample} < NEG_LIM_W);
      assign w_clear_ok = bus.clear_trip[gi] && !w_over;

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_trip       = 1'b0;
`ifdef AUTO_RETRY_EN
        w_rt_next      = r_rt;
        w_retries_next = r_retries;
`endif
        case (r_state)
          ST_HOLD: begin
            if (w_startup_fire) begin
              w_state_next = ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (!w_over) begin
              w_cnt_next = '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE)) begin
              w_trip     = 1'b1;
              w_cnt_next = '0;
`ifdef AUTO_RETRY_EN
              w_rt_next    = '0;
              w_state_next = (r_retries == RC_W'(MAX_RETRY)) ? ST_LOCKOUT : ST_TRIPPED;
`else
              w_state_next = ST_TRIPPED;
`endif
            end else begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end
          ST_TRIPPED: begin
            if (w_clear_ok) begin
              w_state_next = ST_ARMED;
              w_cnt_next   = '0;
`ifdef AUTO_RETRY_EN
              w_retries_next = '0;
            end else if (r_rt == RT_W'(RETRY_CYC - 1)) begin
              w_state_next   = ST_ARMED;
              w_cnt_next     = '0;
              w_rt_next      = '0;
              w_retries_next = r_retries + RC_W'(1);
            end else begin
              w_rt_next = r_rt + RT_W'(1);
`endif
            end
          end
`ifdef AUTO_RETRY_EN
          ST_LOCKOUT: begin
            if (w_clear_ok) begin
              w_state_next   = ST_ARMED;
              w_cnt_next     = '0;
              w_retries_next = '0;
            end
          end
`endif
          default: begin
            w_state_next = ST_HOLD;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_HOLD;
          r_cnt   <= '0;
`ifdef AUTO_RETRY_EN
          r_rt      <= '0;
          r_retries <= '0;
`endif
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
`ifdef AUTO_RETRY_EN
          r_rt      <= w_rt_next;
          r_retries <= w_retries_next;
`endif
        end
      end

      // Relay is closed in HOLD and ARMED, open in every protecting state.
      assign w_relay_next[gi]   = (w_state_next == ST_HOLD) || (w_state_next == ST_ARMED);
      assign w_tripped_next[gi] = !w_relay_next[gi];
      assign w_event_next[gi]   = w_trip;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_relay   <= '1;
      r_tripped <= '0;
      r_event   <= '0;
      r_buzzer  <= 1'b1;
    end else begin
      r_relay   <= w_relay_next;
      r_tripped <= w_tripped_next;
      r_event   <= w_event_next;
      r_buzzer  <= ~|r_tripped;
    end
  end

  assign bus.relay        = r_relay;
  assign bus.tripped      = r_tripped;
  assign bus.trip_event   = r_event;
  assign bus.buzzer       = r_buzzer;
  assign bus.startup_done = r_startup_done;

endmodule

// File: tb/tb_overcurrent_guard_n.sv
// Directed scoreboard bench for overcurrent_guard_n (3 channels, short startup/debounce/retry).
// Build with AUTO_RETRY_EN defined to exercise auto-reclose and lockout.
module tb_overcurrent_guard_n;
  localparam int N_CH = 3;
  localparam int DW   = 16;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   step_no = 0;

  overcurrent_guard_n_if #(.N_CH(N_CH), .DW(DW)) bus ();

  overcurrent_guard_n #(
    .N_CH(N_CH), .DW(DW), .STARTUP_CYC(10), .DEBOUNCE(4),
    .NEG_LIM(32000), .RETRY_CYC(8), .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Packed expectation: {relay, tripped, trip_event, buzzer, startup_done}.
  function automatic logic [10:0] ex(input logic [2:0] rl, input logic [2:0] tr,
                                     input logic [2:0] ev, input logic bz, input logic dn);
    return {rl, tr, ev, bz, dn};
  endfunction

  task automatic set_s(input int ch, input logic [DW-1:0] v);
    bus.samples[ch*DW +: DW] = v;
  endtask

  task automatic set_t(input int ch, input logic [DW-1:0] v);
    bus.thresholds[ch*DW +: DW] = v;
  endtask

  task automatic step(input string tag, input logic [10:0] e);
    exp_t        item;
    logic [10:0] obs;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    obs  = {bus.relay, bus.tripped, bus.trip_event, bus.buzzer, bus.startup_done};
    n_cmp++;
    step_no++;
    $display("step %0d %s rl/tr/ev/bz/dn=%b", step_no, item.tag, obs);
    assert (obs === item.exp) else begin
      n_mis++;
      $error("FAIL %s: observed rl/tr/ev/bz/dn=%b expected %b", item.tag, obs, item.exp);
    end
  endtask

  task automatic steps(input string tag, input int n, input logic [10:0] e);
    for (int k = 0; k < n; k++) step($sformatf("%s[%0d]", tag, k), e);
  endtask

  initial begin
    logic [10:0] idle;
    idle = ex(3'b111, 3'b000, 3'b000, 1'b1, 1'b1);

    reset          = 1'b1;
    bus.samples    = '0;
    bus.thresholds = '0;
    bus.clear_trip = '0;
    for (int c = 0; c < N_CH; c++) set_t(c, 16'd500);
    steps("reset", 2, ex(3'b111, 3'b000, 3'b000, 1'b1, 1'b0));

    // Startup hold, then debounce to trip on channel 0.
    set_s(0, 16'd900);
    reset = 1'b0;
    steps("t1_hold", 9, ex(3'b111, 3'b000, 3'b000, 1'b1, 1'b0));
    step("t1_done", idle);
    steps("t1_count", 4, idle);
    step("t1_trip", ex(3'b110, 3'b001, 3'b001, 1'b1, 1'b1));
    step("t1_buzz", ex(3'b110, 3'b001, 3'b000, 1'b0, 1'b1));
    set_s(0, 16'd100);
    bus.clear_trip = 3'b001;
    step("t1_clear", ex(3'b111, 3'b000, 3'b000, 1'b0, 1'b1));
    bus.clear_trip = 3'b000;
    step("t1_rearm", idle);

    // Debounce break, negative codes and equality on channel 1.
    set_s(1, 16'd900);
    steps("t2_over_a", 4, idle);
    set_s(1, 16'd400);
    step("t2_break_a", idle);
    set_s(1, 16'd900);
    steps("t2_over_b", 4, idle);
    set_s(1, 16'd400);
    step("t2_break_b", idle);
    set_s(1, 16'd40000);
    steps("t2_neg", 8, idle);
    set_s(1, 16'd32000);
    steps("t2_neglim", 8, idle);
    set_s(1, 16'd500);
    steps("t2_equal", 8, idle);

    // Latch and clear on channel 1; clear ignored while still over.
    set_s(1, 16'd31999);
    steps("t3_count", 4, idle);
    step("t3_trip", ex(3'b101, 3'b010, 3'b010, 1'b1, 1'b1));
    set_s(1, 16'd900);
    bus.clear_trip = 3'b010;
    steps("t3_clr_over", 3, ex(3'b101, 3'b010, 3'b000, 1'b0, 1'b1));
    set_s(1, 16'd100);
    step("t3_clear", ex(3'b111, 3'b000, 3'b000, 1'b0, 1'b1));
    bus.clear_trip = 3'b000;
    step("t3_buzz_off", idle);

    // Simultaneous trips on channels 0 and 2, then reset mid-trip.
    set_s(1, 16'd0);
    set_s(0, 16'd900);
    set_s(2, 16'd501);
    steps("t4_count", 4, idle);
    step("t4_trip", ex(3'b010, 3'b101, 3'b101, 1'b1, 1'b1));
    step("t4_buzz", ex(3'b010, 3'b101, 3'b000, 1'b0, 1'b1));
    reset = 1'b1;
    step("t4_reset", ex(3'b111, 3'b000, 3'b000, 1'b1, 1'b0));
    reset = 1'b0;
    steps("t4_hold", 9, ex(3'b111, 3'b000, 3'b000, 1'b1, 1'b0));
    step("t4_done", idle);
    steps("t4_count2", 4, idle);
    step("t4_retrip", ex(3'b010, 3'b101, 3'b101, 1'b1, 1'b1));
    set_s(0, 16'd0);
    set_s(2, 16'd0);
    bus.clear_trip = 3'b101;
    step("t4_clear", ex(3'b111, 3'b000, 3'b000, 1'b0, 1'b1));
    bus.clear_trip = 3'b000;
    step("t4_rearm", idle);

    // Runtime threshold change on channel 0.
    set_t(0, 16'd1000);
    set_s(0, 16'd600);
    steps("t6_below", 6, idle);
    set_t(0, 16'd300);
    steps("t6_count", 4, idle);
    step("t6_trip", ex(3'b110, 3'b001, 3'b001, 1'b1, 1'b1));
    set_t(0, 16'd1000);
    steps("t6_latched", 6, ex(3'b110, 3'b001, 3'b000, 1'b0, 1'b1));
`ifndef AUTO_RETRY_EN
    steps("t6_latched_long", 20, ex(3'b110, 3'b001, 3'b000, 1'b0, 1'b1));
`else
    set_s(0, 16'd0);
    bus.clear_trip = 3'b001;
    step("t5_prep_clear", ex(3'b111, 3'b000, 3'b000, 1'b0, 1'b1));
    bus.clear_trip = 3'b000;
    step("t5_prep_rearm", idle);

    // Continuous overload on channel 2: two recloses, then lockout.
    set_s(2, 16'd900);
    for (int r = 0; r < 2; r++) begin
      steps($sformatf("t5_count%0d", r), 4, idle);
      step($sformatf("t5_trip%0d", r), ex(3'b011, 3'b100, 3'b100, 1'b1, 1'b1));
      steps($sformatf("t5_open%0d", r), 7, ex(3'b011, 3'b100, 3'b000, 1'b0, 1'b1));
      step($sformatf("t5_reclose%0d", r), ex(3'b111, 3'b000, 3'b000, 1'b0, 1'b1));
    end
    steps("t5_count_lk", 4, idle);
    step("t5_trip_lk", ex(3'b011, 3'b100, 3'b100, 1'b1, 1'b1));
    steps("t5_lockout", 12, ex(3'b011, 3'b100, 3'b000, 1'b0, 1'b1));
    set_s(2, 16'd0);
    bus.clear_trip = 3'b100;
    step("t5_lk_clear", ex(3'b111, 3'b000, 3'b000, 1'b0, 1'b1));
    bus.clear_trip = 3'b000;
    step("t5_lk_rearm", idle);
    // Retries were cleared, so the next trip recloses again instead of locking out.
    set_s(2, 16'd900);
    steps("t5_count_post", 4, idle);
    step("t5_trip_post", ex(3'b011, 3'b100, 3'b100, 1'b1, 1'b1));
    steps("t5_open_post", 7, ex(3'b011, 3'b100, 3'b000, 1'b0, 1'b1));
    step("t5_reclose_post", ex(3'b111, 3'b000, 3'b000, 1'b0, 1'b1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
